// File: rtl/ps2_pkg.sv
// Shared state encodings, Set-2 byte constants and the decoded key-event record
// for the PS/2 scan-code decoder.
package ps2_pkg;

    localparam int CODE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    localparam logic [CODE_W-1:0] PS2_EXT   = 8'hE0;
    localparam logic [CODE_W-1:0] PS2_BRK   = 8'hF0;
    localparam logic [CODE_W-1:0] PS2_PAUSE = 8'hE1;
    localparam logic [CODE_W-1:0] PS2_BAT   = 8'hAA;
    localparam logic [CODE_W-1:0] PS2_OVR0  = 8'h00;
    localparam logic [CODE_W-1:0] PS2_OVR1  = 8'hFF;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              ext;
        logic              rel;
    } key_evt_t;

    // Bytes that can never be part of a key sequence inside a prefix.
    function automatic logic is_bad_in_prefix(input logic [CODE_W-1:0] b);
        return (b == PS2_OVR0) || (b == PS2_OVR1) || (b == PS2_PAUSE) ||
               (b == PS2_EXT)  || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_timeout.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TERMINAL-1.
module ps2_timeout #(
    parameter int TERMINAL = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int W = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end

    assign expire = en && (cnt == W'(TERMINAL - 1));

endmodule

// File: rtl/ps2_scan_decoder.sv
// Set-2 scan-code decoder: folds E0/F0/E1 prefix sequences into key events,
// keeps the last two make codes, flags errors. Optional PS2_DEC_TYPEMATIC_FILTER_EN.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int PAUSE_SKIP     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              evt_valid,
    output logic [CODE_W-1:0] evt_code,
    output logic              evt_ext,
    output logic              evt_release,
    output logic [CODE_W-1:0] disp_last,
    output logic [CODE_W-1:0] disp_prev,
    output logic              err
);

    localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

    state_t            state, state_nxt;
    logic [SKIP_W-1:0] skip_cnt, skip_nxt;
    logic              tmo_expire;
    logic              dec_fire, dec_err, suppress, emit;
    key_evt_t          dec;
    logic              is_ovr;

    assign is_ovr = (byte_in == PS2_OVR0) || (byte_in == PS2_OVR1);

    ps2_timeout #(.TERMINAL(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (byte_valid || state == ST_IDLE),
        .en     (state != ST_IDLE),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (byte_in == PS2_EXT)
                        state_nxt = ST_EXT;
                    else if (byte_in == PS2_BRK)
                        state_nxt = ST_BRK;
                    else if (byte_in == PS2_PAUSE) begin
                        state_nxt = ST_SKIP;
                        skip_nxt  = SKIP_W'(PAUSE_SKIP);
                    end
                end
                ST_EXT: begin
                    if (byte_in == PS2_BRK)
                        state_nxt = ST_EXT_BRK;
                    else if (byte_in != PS2_EXT)
                        state_nxt = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_nxt = skip_cnt - 1'b1;
                    if (skip_cnt == SKIP_W'(1))
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (tmo_expire) begin
            state_nxt = ST_IDLE;
        end
    end

    // A byte on the expiry cycle takes priority over the timeout.
    always_comb begin
        dec_fire = 1'b0;
        dec_err  = 1'b0;
        dec      = '{code: byte_in, ext: 1'b0, rel: 1'b0};
        if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_ovr)
                        dec_err = 1'b1;
                    else if (byte_in != PS2_EXT && byte_in != PS2_BRK &&
                             byte_in != PS2_PAUSE && byte_in != PS2_BAT)
                        dec_fire = 1'b1;
                end
                ST_EXT: begin
                    dec.ext = 1'b1;
                    if (is_ovr || byte_in == PS2_PAUSE)
                        dec_err = 1'b1;
                    else if (byte_in != PS2_BRK && byte_in != PS2_EXT)
                        dec_fire = 1'b1;
                end
                ST_BRK, ST_EXT_BRK: begin
                    dec.ext = (state == ST_EXT_BRK);
                    dec.rel = 1'b1;
                    if (is_bad_in_prefix(byte_in))
                        dec_err = 1'b1;
                    else
                        dec_fire = 1'b1;
                end
                ST_SKIP: begin
                    dec.code = PS2_PAUSE;
                    dec_fire = (skip_cnt == SKIP_W'(1));
                end
                default: ;
            endcase
        end else if (tmo_expire) begin
            dec_err = 1'b1;
        end
    end

`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
    logic [CODE_W-1:0] held_code;
    logic              held_ext, held_vld, held_match;

    assign held_match = held_vld && (held_code == dec.code) && (held_ext == dec.ext);
    assign suppress   = !dec.rel && held_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_code <= '0;
            held_ext  <= 1'b0;
            held_vld  <= 1'b0;
        end else if (dec_fire) begin
            if (!dec.rel && !held_match) begin
                held_code <= dec.code;
                held_ext  <= dec.ext;
                held_vld  <= 1'b1;
            end else if (dec.rel && held_match) begin
                held_vld  <= 1'b0;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign emit = dec_fire && !suppress;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid   <= 1'b0;
            evt_code    <= '0;
            evt_ext     <= 1'b0;
            evt_release <= 1'b0;
            disp_last   <= '0;
            disp_prev   <= '0;
            err         <= 1'b0;
        end else begin
            evt_valid <= emit;
            err       <= dec_err;
            if (emit) begin
                evt_code    <= dec.code;
                evt_ext     <= dec.ext;
                evt_release <= dec.rel;
                if (!dec.rel) begin
                    disp_prev <= disp_last;
                    disp_last <= dec.code;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: a sequence-level reference model checked
// every cycle, plus literal expectations on key scenarios.
module tb_ps2_scan_decoder;

    localparam int TO   = 16;
    localparam int SKIP = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       evt_valid, evt_ext, evt_release, err;
    logic [7:0] evt_code, disp_last, disp_prev;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    int er_cnt = 0;

    always #5 clk = ~clk;

    ps2_scan_decoder #(.TIMEOUT_CYCLES(TO), .PAUSE_SKIP(SKIP)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext),
        .evt_release(evt_release), .disp_last(disp_last), .disp_prev(disp_prev),
        .err(err)
    );

    // Reference model: bytes of the pending prefix sequence are kept as a list.
    logic [7:0] pend[$];
    int         quiet;
    logic       x_valid, x_err, x_ext, x_rel;
    logic [7:0] x_code, x_last, x_prev;
    logic       h_vld;
    logic [7:0] h_code;
    logic       h_ext;

    task automatic report(input logic [7:0] c, input logic e, input logic r);
        logic same;
        same = h_vld && h_code == c && h_ext == e;
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
        if (!r && same) return;
        if (!r) begin h_vld = 1'b1; h_code = c; h_ext = e; end
        else if (same) h_vld = 1'b0;
`endif
        x_valid = 1'b1; x_code = c; x_ext = e; x_rel = r;
        if (!r) begin x_prev = x_last; x_last = c; end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic bad, pre_ext, pre_brk;
        bad = (b == 8'h00) || (b == 8'hFF);
        if (pend.size() > 0 && pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == SKIP + 1) begin
                report(8'hE1, 1'b0, 1'b0);
                pend.delete();
            end
        end else if (pend.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) pend.push_back(b);
            else if (bad) x_err = 1'b1;
            else if (b != 8'hAA) report(b, 1'b0, 1'b0);
        end else begin
            pre_ext = (pend[0] == 8'hE0);
            pre_brk = (pend[pend.size()-1] == 8'hF0);
            if (b == 8'hF0 && !pre_brk) pend.push_back(b);
            else if (b == 8'hE0 && !pre_brk) ;
            else if (bad || b == 8'hE0 || b == 8'hF0 || b == 8'hE1) begin
                x_err = 1'b1;
                pend.delete();
            end else begin
                report(b, pre_ext, pre_brk);
                pend.delete();
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete(); quiet = 0;
            x_valid = 0; x_err = 0; x_code = 0; x_ext = 0; x_rel = 0;
            x_last = 0; x_prev = 0; h_vld = 0; h_code = 0; h_ext = 0;
        end else begin
            x_valid = 1'b0;
            x_err   = 1'b0;
            if (byte_valid) begin
                quiet = 0;
                model_byte(byte_in);
            end else if (pend.size() > 0) begin
                quiet++;
                if (quiet >= TO) begin
                    x_err = 1'b1;
                    pend.delete();
                    quiet = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({evt_valid, err, evt_code, evt_ext, evt_release, disp_last, disp_prev} !==
            {x_valid, x_err, x_code, x_ext, x_rel, x_last, x_prev}) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got v=%b e=%b code=%h ext=%b rel=%b last=%h prev=%h exp v=%b e=%b code=%h ext=%b rel=%b last=%h prev=%h",
                     $time, evt_valid, err, evt_code, evt_ext, evt_release, disp_last, disp_prev,
                     x_valid, x_err, x_code, x_ext, x_rel, x_last, x_prev);
        end
        if (evt_valid) ev_cnt++;
        if (err) er_cnt++;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        byte_in = b; byte_valid = 1'b1;
        @(posedge clk); #2;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    int e0, r0;

    initial begin
        idle(2);
        chk("reset_evt_valid", evt_valid, 0);
        chk("reset_disp_last", disp_last, 0);
        rst_n = 1'b1;
        idle(1);

        // Plain make, then extended break, then extended make
        e0 = ev_cnt;
        put(8'h1C);
        chk("make_valid", evt_valid, 1);
        chk("make_code", evt_code, 8'h1C);
        chk("make_flags", {evt_ext, evt_release}, 0);
        chk("make_disp_last", disp_last, 8'h1C);
        chk("make_disp_prev", disp_prev, 8'h00);
        idle(2);
        r0 = er_cnt; e0 = ev_cnt;
        put(8'hE0); put(8'hF0); put(8'h74);
        chk("extbrk_code", evt_code, 8'h74);
        chk("extbrk_flags", {evt_ext, evt_release}, 2'b11);
        chk("extbrk_disp", disp_last, 8'h1C);
        idle(2);
        chk("extbrk_one_event", ev_cnt - e0, 1);
        chk("extbrk_no_err", er_cnt - r0, 0);
        put(8'hE0); put(8'h75);
        chk("ext_make_flags", {evt_ext, evt_release}, 2'b10);
        chk("ext_make_prev", disp_prev, 8'h1C);
        idle(2);

        // Pause sequence
        do_reset();
        e0 = ev_cnt; r0 = er_cnt;
        put(8'hE1); put(8'h14); put(8'h77); put(8'hE1);
        put(8'hF0); put(8'h14); put(8'hF0);
        chk("pause_no_early_evt", ev_cnt - e0, 0);
        put(8'h77);
        chk("pause_code", evt_code, 8'hE1);
        idle(3);
        chk("pause_one_event", ev_cnt - e0, 1);
        chk("pause_no_err", er_cnt - r0, 0);

        // Timeout after F0, then a normal make
        do_reset();
        r0 = er_cnt; e0 = ev_cnt;
        put(8'hF0);
        idle(TO + 3);
        chk("timeout_err", er_cnt - r0, 1);
        chk("timeout_no_evt", ev_cnt - e0, 0);
        put(8'h1C);
        chk("after_timeout_make", {evt_valid, evt_release, evt_code}, {2'b10, 8'h1C});

        // Byte arriving on the expiry cycle wins
        idle(2);
        r0 = er_cnt;
        put(8'hF0);
        idle(TO - 1);
        put(8'h2A);
        chk("expiry_byte_wins", {evt_valid, evt_release, evt_code}, {2'b11, 8'h2A});
        idle(TO + 2);
        chk("expiry_no_err", er_cnt - r0, 0);

        // Protocol errors, BAT, duplicate E0
        r0 = er_cnt; e0 = ev_cnt;
        put(8'hF0); put(8'hF0);
        chk("brk_brk_err", err, 1);
        put(8'hFF);
        chk("ovr_err", err, 1);
        put(8'hAA);
        put(8'hE0); put(8'hE0); put(8'h75);
        chk("dup_ext_make", {evt_valid, evt_ext, evt_code}, {2'b11, 8'h75});
        idle(2);
        chk("err_count", er_cnt - r0, 2);
        chk("evt_count", ev_cnt - e0, 1);

        // Reset mid-sequence
        e0 = ev_cnt;
        put(8'hE0);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {evt_valid, err, evt_code, disp_last, disp_prev}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(TO + 2);
        chk("midrst_no_evt", ev_cnt - e0, 0);

        // Typematic repeat
        do_reset();
        e0 = ev_cnt;
        put(8'h1C); put(8'h1C); put(8'h1C); put(8'hF0); put(8'h1C); put(8'h1C);
        idle(2);
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
        chk("typematic_events", ev_cnt - e0, 3);
`else
        chk("typematic_events", ev_cnt - e0, 5);
`endif
        chk("typematic_last", disp_last, 8'h1C);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
